// File: rtl/maple_pkg.sv
// Maple Bus receive frame checker: shared types and constants.
// State encoding, header byte positions and tuser flag positions.
package maple_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    PAYLOAD,
    CRC,
    DRAIN
  } state_t;

  localparam int LEN_IDX  = 0;
  localparam int SRC_IDX  = 1;
  localparam int DEST_IDX = 2;
  localparam int CMD_IDX  = 3;

  localparam int TUSER_CRC_ERR = 0;
  localparam int TUSER_LEN_ERR = 1;

endpackage

// File: rtl/maple_sat_counter.sv
// Saturating up-counter used for frame and error statistics.
// Cleared only by the asynchronous reset; holds at all-ones.
module maple_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  // Count up on inc, stop at all-ones
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/maple_rx_frame_checker.sv
// Packs Maple Bus rx bytes into 32-bit words and checks each frame.
// Final word is held until the checksum byte; errors ride on tuser.
module maple_rx_frame_checker
  import maple_pkg::*;
#(
  parameter int C_AXIS_TDATA_WIDTH   = 8,
  parameter int C_M_AXIS_TDATA_WIDTH = 32,
  parameter int C_CNT_WIDTH          = 16
) (
  input  logic                            aclk,
  input  logic                            aresetn,
  input  logic                            clear,
  input  logic [C_AXIS_TDATA_WIDTH-1:0]   s_axis_tdata,
  input  logic                            s_axis_tvalid,
  output logic                            s_axis_tready,
  input  logic                            s_axis_tlast,
  output logic [C_M_AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
  output logic                            m_axis_tvalid,
  input  logic                            m_axis_tready,
  output logic                            m_axis_tlast,
  output logic [1:0]                      m_axis_tuser,
  output logic [C_CNT_WIDTH-1:0]          frame_count,
  output logic [C_CNT_WIDTH-1:0]          crc_err_count,
  output logic [C_CNT_WIDTH-1:0]          len_err_count
);

  state_t      r_state, r_state_n;
  logic [1:0]  r_idx, r_idx_n;
  logic [23:0] r_word, r_word_n;
  logic [7:0]  r_xor, r_xor_n;
  logic [7:0]  r_len, r_len_n;
  logic [7:0]  r_wcnt, r_wcnt_n;

  logic        r_pend_vld, r_pend_vld_n;
  logic        r_pend_hold, r_pend_hold_n;
  logic [31:0] r_pend_data, r_pend_data_n;
  logic        r_pend_last, r_pend_last_n;
  logic [1:0]  r_pend_user, r_pend_user_n;

  logic        r_out_vld, r_out_vld_n;
  logic [31:0] r_out_data, r_out_data_n;
  logic        r_out_last, r_out_last_n;
  logic [1:0]  r_out_user, r_out_user_n;

  logic [7:0]  w_byte;
  logic [31:0] w_word;
  logic        w_out_free;
  logic        w_collect;
  logic        w_produce;
  logic        w_ready;
  logic        w_acc;
  logic        w_hs_last;

  logic        w_new_vld;
  logic        w_new_last;
  logic        w_new_hold;
  logic [1:0]  w_new_user;
  logic        w_release;
  logic [1:0]  w_rel_user;

  assign w_byte     = s_axis_tdata[7:0];
  assign w_out_free = !r_out_vld || m_axis_tready;
  assign w_collect  = (r_state == IDLE) ||
                      (r_state == HDR) ||
                      (r_state == PAYLOAD);
  assign w_produce  = (w_collect &&
                       ((r_idx == 2'(CMD_IDX)) || s_axis_tlast)) ||
                      (r_state == CRC);
  assign w_ready    = !(w_produce && r_pend_vld && !w_out_free);
  assign s_axis_tready = aresetn && !clear && w_ready;
  assign w_acc      = s_axis_tvalid && s_axis_tready;
  assign w_hs_last  = r_out_vld && m_axis_tready && r_out_last;

  assign m_axis_tdata  = r_out_data;
  assign m_axis_tvalid = r_out_vld;
  assign m_axis_tlast  = r_out_last;
  assign m_axis_tuser  = r_out_user;

  // Current byte merged into the partial word, upper bytes zero
  always_comb begin
    w_word = 32'h0;
    unique case (r_idx)
      2'(LEN_IDX):  w_word = {24'h0, w_byte};
      2'(SRC_IDX):  w_word = {16'h0, w_byte, r_word[7:0]};
      2'(DEST_IDX): w_word = {8'h0, w_byte, r_word[15:0]};
      2'(CMD_IDX):  w_word = {w_byte, r_word};
      default:      w_word = 32'h0;
    endcase
  end

  // Next state, word packing and output/pending slot steering
  always_comb begin
    r_state_n     = r_state;
    r_idx_n       = r_idx;
    r_word_n      = r_word;
    r_xor_n       = r_xor;
    r_len_n       = r_len;
    r_wcnt_n      = r_wcnt;
    r_pend_vld_n  = r_pend_vld;
    r_pend_hold_n = r_pend_hold;
    r_pend_data_n = r_pend_data;
    r_pend_last_n = r_pend_last;
    r_pend_user_n = r_pend_user;
    r_out_vld_n   = r_out_vld;
    r_out_data_n  = r_out_data;
    r_out_last_n  = r_out_last;
    r_out_user_n  = r_out_user;
    w_new_vld     = 1'b0;
    w_new_last    = 1'b0;
    w_new_hold    = 1'b0;
    w_new_user    = 2'b00;
    w_release     = 1'b0;
    w_rel_user    = 2'b00;

    if (w_acc) begin
      unique case (r_state)
        IDLE, HDR, PAYLOAD: begin
          r_xor_n = r_xor ^ w_byte;
          r_idx_n = r_idx + 2'd1;
          unique case (r_idx)
            2'(LEN_IDX):  r_word_n[7:0]   = w_byte;
            2'(SRC_IDX):  r_word_n[15:8]  = w_byte;
            2'(DEST_IDX): r_word_n[23:16] = w_byte;
            default:      ;
          endcase
          if (r_state == IDLE) begin
            r_len_n   = w_byte;
            r_state_n = HDR;
          end
          if (s_axis_tlast) begin
            w_new_vld  = 1'b1;
            w_new_last = 1'b1;
            w_new_user[TUSER_LEN_ERR] = 1'b1;
            r_state_n  = IDLE;
            r_idx_n    = 2'd0;
            r_xor_n    = 8'h0;
          end else if (r_idx == 2'(CMD_IDX)) begin
            w_new_vld = 1'b1;
            if (r_state == HDR) begin
              if (r_len == 8'd0) begin
                w_new_hold = 1'b1;
                w_new_last = 1'b1;
                r_state_n  = CRC;
              end else begin
                r_wcnt_n  = 8'd0;
                r_state_n = PAYLOAD;
              end
            end else if (r_wcnt == r_len - 8'd1) begin
              w_new_hold = 1'b1;
              w_new_last = 1'b1;
              r_state_n  = CRC;
            end else begin
              r_wcnt_n = r_wcnt + 8'd1;
            end
          end
        end
        CRC: begin
          w_release = 1'b1;
          w_rel_user[TUSER_CRC_ERR] = (w_byte != r_xor);
          w_rel_user[TUSER_LEN_ERR] = !s_axis_tlast;
          r_state_n = s_axis_tlast ? IDLE : DRAIN;
          r_xor_n   = 8'h0;
          r_idx_n   = 2'd0;
        end
        DRAIN: begin
          if (s_axis_tlast) begin
            r_state_n = IDLE;
          end
        end
        default: ;
      endcase
    end

    if (w_release) begin
      r_out_vld_n   = 1'b1;
      r_out_data_n  = r_pend_data;
      r_out_last_n  = 1'b1;
      r_out_user_n  = w_rel_user;
      r_pend_vld_n  = 1'b0;
      r_pend_hold_n = 1'b0;
    end else if (w_new_vld) begin
      if (r_pend_vld) begin
        r_out_vld_n   = 1'b1;
        r_out_data_n  = r_pend_data;
        r_out_last_n  = r_pend_last;
        r_out_user_n  = r_pend_user;
        r_pend_vld_n  = 1'b1;
        r_pend_hold_n = w_new_hold;
        r_pend_data_n = w_word;
        r_pend_last_n = w_new_last;
        r_pend_user_n = w_new_user;
      end else if (w_out_free && !w_new_hold) begin
        r_out_vld_n  = 1'b1;
        r_out_data_n = w_word;
        r_out_last_n = w_new_last;
        r_out_user_n = w_new_user;
      end else begin
        r_pend_vld_n  = 1'b1;
        r_pend_hold_n = w_new_hold;
        r_pend_data_n = w_word;
        r_pend_last_n = w_new_last;
        r_pend_user_n = w_new_user;
        if (w_out_free) begin
          r_out_vld_n = 1'b0;
        end
      end
    end else if (r_pend_vld && !r_pend_hold && w_out_free) begin
      r_out_vld_n  = 1'b1;
      r_out_data_n = r_pend_data;
      r_out_last_n = r_pend_last;
      r_out_user_n = r_pend_user;
      r_pend_vld_n = 1'b0;
    end else if (m_axis_tready) begin
      r_out_vld_n = 1'b0;
    end
  end

  // State and datapath registers; clear acts like reset here
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state     <= IDLE;
      r_idx       <= 2'd0;
      r_word      <= 24'h0;
      r_xor       <= 8'h0;
      r_len       <= 8'h0;
      r_wcnt      <= 8'h0;
      r_pend_vld  <= 1'b0;
      r_pend_hold <= 1'b0;
      r_pend_data <= 32'h0;
      r_pend_last <= 1'b0;
      r_pend_user <= 2'b00;
      r_out_vld   <= 1'b0;
      r_out_data  <= 32'h0;
      r_out_last  <= 1'b0;
      r_out_user  <= 2'b00;
    end else if (clear) begin
      r_state     <= IDLE;
      r_idx       <= 2'd0;
      r_word      <= 24'h0;
      r_xor       <= 8'h0;
      r_len       <= 8'h0;
      r_wcnt      <= 8'h0;
      r_pend_vld  <= 1'b0;
      r_pend_hold <= 1'b0;
      r_pend_data <= 32'h0;
      r_pend_last <= 1'b0;
      r_pend_user <= 2'b00;
      r_out_vld   <= 1'b0;
      r_out_data  <= 32'h0;
      r_out_last  <= 1'b0;
      r_out_user  <= 2'b00;
    end else begin
      r_state     <= r_state_n;
      r_idx       <= r_idx_n;
      r_word      <= r_word_n;
      r_xor       <= r_xor_n;
      r_len       <= r_len_n;
      r_wcnt      <= r_wcnt_n;
      r_pend_vld  <= r_pend_vld_n;
      r_pend_hold <= r_pend_hold_n;
      r_pend_data <= r_pend_data_n;
      r_pend_last <= r_pend_last_n;
      r_pend_user <= r_pend_user_n;
      r_out_vld   <= r_out_vld_n;
      r_out_data  <= r_out_data_n;
      r_out_last  <= r_out_last_n;
      r_out_user  <= r_out_user_n;
    end
  end

  maple_sat_counter #(.W(C_CNT_WIDTH)) u_frame_cnt (
    .clk   (aclk),
    .rst_n (aresetn),
    .inc   (w_hs_last),
    .count (frame_count)
  );

  maple_sat_counter #(.W(C_CNT_WIDTH)) u_crc_cnt (
    .clk   (aclk),
    .rst_n (aresetn),
    .inc   (w_hs_last && r_out_user[TUSER_CRC_ERR]),
    .count (crc_err_count)
  );

  maple_sat_counter #(.W(C_CNT_WIDTH)) u_len_cnt (
    .clk   (aclk),
    .rst_n (aresetn),
    .inc   (w_hs_last && r_out_user[TUSER_LEN_ERR]),
    .count (len_err_count)
  );

endmodule

// File: tb/tb_maple_rx_frame_checker.sv
// Bench for maple_rx_frame_checker: directed frames plus random
// frames under backpressure, checked against a packet-level model.
module tb_maple_rx_frame_checker;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic        clear = 1'b0;
  logic [7:0]  s_axis_tdata = 8'h0;
  logic        s_axis_tvalid = 1'b0;
  logic        s_axis_tready;
  logic        s_axis_tlast = 1'b0;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready = 1'b1;
  logic        m_axis_tlast;
  logic [1:0]  m_axis_tuser;
  logic [15:0] frame_count;
  logic [15:0] crc_err_count;
  logic [15:0] len_err_count;

  int n_tests = 0;
  int n_fail  = 0;
  bit bp = 1'b0;

  logic [34:0] exp_q[$];
  int exp_frames = 0;
  int exp_crc = 0;
  int exp_len = 0;

  logic        stall_prev = 1'b0;
  logic [34:0] stall_word = '0;

  maple_rx_frame_checker dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .clear         (clear),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tlast  (s_axis_tlast),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tuser  (m_axis_tuser),
    .frame_count   (frame_count),
    .crc_err_count (crc_err_count),
    .len_err_count (len_err_count)
  );

  always #5 aclk = ~aclk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void push_exp(input logic [31:0] d,
                                   input logic l,
                                   input logic [1:0] u);
    exp_q.push_back({u, l, d});
    if (l) begin
      if (exp_frames < 65535) exp_frames++;
      if (u[0] && exp_crc < 65535) exp_crc++;
      if (u[1] && exp_len < 65535) exp_len++;
    end
  endfunction

  // Packet-level reference: one tlast-delimited packet -> words
  function automatic void model_packet(input logic [7:0] pkt[$]);
    int n, full, nb, nw;
    logic [7:0]  x;
    logic [1:0]  u;
    logic [31:0] d;
    n    = pkt.size();
    full = 4 + 4 * int'(pkt[0]) + 1;
    if (n < full) begin
      nb = n;
      u  = 2'b10;
    end else begin
      nb = full - 1;
      x  = 8'h0;
      for (int i = 0; i < full - 1; i++) x ^= pkt[i];
      u = {n > full, pkt[full-1] != x};
    end
    nw = (nb + 3) / 4;
    for (int w = 0; w < nw; w++) begin
      d = 32'h0;
      for (int k = 0; k < 4; k++)
        if (4 * w + k < nb) d[8*k +: 8] = pkt[4*w+k];
      push_exp(d, w == nw - 1, (w == nw - 1) ? u : 2'b00);
    end
  endfunction

  // Output monitor: ordered word check and stall stability
  always @(negedge aclk) begin
    if (!aresetn || clear) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        chk("stall_vld", m_axis_tvalid, 1'b1);
        chk("stall_data", {m_axis_tuser, m_axis_tlast, m_axis_tdata},
            stall_word);
      end
      if (m_axis_tvalid && m_axis_tready) begin
        if (exp_q.size() == 0)
          chk("extra_word", exp_q.size(), 1);
        else
          chk("word", {m_axis_tuser, m_axis_tlast, m_axis_tdata},
              exp_q.pop_front());
      end
      stall_prev = m_axis_tvalid && !m_axis_tready;
      stall_word = {m_axis_tuser, m_axis_tlast, m_axis_tdata};
    end
  end

  initial begin
    forever begin
      @(posedge aclk);
      #1;
      m_axis_tready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic send_byte(input logic [7:0] b, input logic l);
    int t;
    logic rdy;
    t = 0;
    s_axis_tdata  = b;
    s_axis_tlast  = l;
    s_axis_tvalid = 1'b1;
    forever begin
      @(negedge aclk);
      rdy = s_axis_tready;
      @(posedge aclk);
      #1;
      if (rdy) break;
      t++;
      if (t > 2000) begin
        chk("s_ready_timeout", t, 0);
        break;
      end
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic send_range(input logic [7:0] p[$], input int lo,
                            input int hi, input bit gaps);
    for (int i = lo; i <= hi; i++) begin
      send_byte(p[i], i == p.size() - 1);
      if (gaps && $urandom_range(0, 3) == 0) begin
        @(posedge aclk);
        #1;
      end
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 || m_axis_tvalid) begin
      @(posedge aclk);
      #1;
      t++;
      if (t > 5000) begin
        chk("drain_timeout", exp_q.size(), 0);
        break;
      end
    end
    repeat (2) @(posedge aclk);
    #1;
  endtask

  task automatic check_counters(input string tag);
    chk({tag, "_frames"}, frame_count, exp_frames);
    chk({tag, "_crc"}, crc_err_count, exp_crc);
    chk({tag, "_len"}, len_err_count, exp_len);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_tvalid"}, m_axis_tvalid, 0);
    chk({tag, "_tdata"}, m_axis_tdata, 0);
    chk({tag, "_tlast_user"}, {m_axis_tlast, m_axis_tuser}, 0);
    chk({tag, "_s_tready"}, s_axis_tready, 0);
    chk({tag, "_cnts"}, {frame_count, crc_err_count, len_err_count}, 0);
  endtask

  logic [7:0] f1[$];
  logic [7:0] p[$];

  initial begin
    f1 = '{8'h01, 8'h20, 8'h00, 8'h01, 8'hAA, 8'hBB, 8'hCC, 8'hDD,
           8'h20};
    repeat (3) @(posedge aclk);
    #1;
    check_reset_outputs("reset");
    aresetn = 1'b1;
    @(posedge aclk);
    #1;

    // Good frame, with header and final-word latency
    push_exp(32'h01002001, 1'b0, 2'b00);
    push_exp(32'hDDCCBBAA, 1'b1, 2'b00);
    send_range(f1, 0, 3, 1'b0);
    chk("lat_hdr", {m_axis_tvalid, m_axis_tdata}, {1'b1, 32'h01002001});
    send_range(f1, 4, 8, 1'b0);
    chk("lat_final", {m_axis_tvalid, m_axis_tlast, m_axis_tdata},
        {2'b11, 32'hDDCCBBAA});
    drain();
    check_counters("t1");

    // LEN = 0
    push_exp(32'h01002000, 1'b1, 2'b00);
    p = '{8'h00, 8'h20, 8'h00, 8'h01, 8'h21};
    send_range(p, 0, 4, 1'b0);
    drain();
    check_counters("t2");

    // Bad checksum
    push_exp(32'h01002001, 1'b0, 2'b00);
    push_exp(32'hDDCCBBAA, 1'b1, 2'b01);
    p = f1;
    p[8] = 8'h21;
    send_range(p, 0, 8, 1'b0);
    drain();
    check_counters("t3");

    // Truncated after BB
    push_exp(32'h01002001, 1'b0, 2'b00);
    push_exp(32'h0000BBAA, 1'b1, 2'b10);
    p = '{8'h01, 8'h20, 8'h00, 8'h01, 8'hAA, 8'hBB};
    send_range(p, 0, 5, 1'b0);
    drain();
    check_counters("t4");

    // Missing tlast on checksum, junk drained, then a good frame
    push_exp(32'h01002001, 1'b0, 2'b00);
    push_exp(32'hDDCCBBAA, 1'b1, 2'b10);
    p = f1;
    p.push_back(8'h11);
    p.push_back(8'h22);
    p.push_back(8'h33);
    send_range(p, 0, 11, 1'b0);
    push_exp(32'h01002001, 1'b0, 2'b00);
    push_exp(32'hDDCCBBAA, 1'b1, 2'b00);
    send_range(f1, 0, 8, 1'b0);
    drain();
    check_counters("t5");

    // Clear mid-header: counters hold, next frame decodes
    p = '{8'h02, 8'h55};
    send_byte(p[0], 1'b0);
    send_byte(p[1], 1'b0);
    clear = 1'b1;
    @(posedge aclk);
    #1;
    clear = 1'b0;
    chk("clear_tvalid", m_axis_tvalid, 0);
    check_counters("clear");
    push_exp(32'h01002000, 1'b1, 2'b00);
    p = '{8'h00, 8'h20, 8'h00, 8'h01, 8'h21};
    send_range(p, 0, 4, 1'b0);
    drain();
    check_counters("post_clear");

    // Random frames under backpressure, one mid-payload reset
    bp = 1'b1;
    for (int f = 0; f < 100; f++) begin
      int len, full, r, n;
      logic [7:0] x;
      if (f == 50) begin
        p = '{8'h03, 8'h10, 8'h20, 8'h30,
              8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        push_exp(32'h30201003, 1'b0, 2'b00);
        push_exp(32'h04030201, 1'b0, 2'b00);
        for (int i = 0; i < p.size(); i++) send_byte(p[i], 1'b0);
        drain();
        aresetn = 1'b0;
        #1;
        check_reset_outputs("mid_reset");
        @(posedge aclk);
        #1;
        aresetn = 1'b1;
        exp_frames = 0;
        exp_crc = 0;
        exp_len = 0;
      end
      len = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 40))
                                        : int'($urandom_range(0, 6));
      p = {};
      p.push_back(8'(len));
      for (int i = 0; i < 3 + 4 * len; i++)
        p.push_back(8'($urandom_range(0, 255)));
      x = 8'h0;
      foreach (p[i]) x ^= p[i];
      p.push_back(x);
      full = p.size();
      r = $urandom_range(0, 99);
      if (r < 15) begin
        p[full-1] = x ^ 8'($urandom_range(1, 255));
      end else if (r < 30) begin
        n = $urandom_range(1, full - 1);
        while (p.size() > n) void'(p.pop_back());
      end else if (r < 40) begin
        n = $urandom_range(1, 3);
        for (int i = 0; i < n; i++)
          p.push_back(8'($urandom_range(0, 255)));
      end
      model_packet(p);
      send_range(p, 0, p.size() - 1, 1'b1);
    end
    drain();
    check_counters("random");
    chk("queue_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/maple_rx_frame_checker.md
Name: maple_rx_frame_checker

Overview:
Sits downstream of the receive FIFO. It consumes the 8-bit AXI-Stream byte stream produced by the Maple Bus receiver and packs it into 32-bit words for DMA. It also validates each frame's length field and its XOR checksum byte. Results are reported in-band on the last word via tuser, and as saturating error counters for the AXI-Lite control block.

Parameters:
C_AXIS_TDATA_WIDTH, 8, input byte-stream width (fixed at 8; other values unsupported)
C_M_AXIS_TDATA_WIDTH, 32, output word width (fixed at 32)
C_CNT_WIDTH, 16, width of frame and error counters

Ports:
aclk  in  1  clock
aresetn  in  1  reset, asynchronous, active-low
clear  in  1  synchronous soft clear (driven from RESET_RX); same effect as reset except counters hold
s_axis_tdata  in  8  received byte
s_axis_tvalid  in  1  byte valid
s_axis_tready  out  1  byte accepted when tvalid && tready
s_axis_tlast  in  1  last byte of received packet
m_axis_tdata  out  32  packed word; first byte of each word in [7:0]
m_axis_tvalid  out  1  word valid
m_axis_tready  in  1  downstream ready
m_axis_tlast  out  1  last word of frame
m_axis_tuser  out  2  on tlast word: [0] crc_err, [1] len_err; 0 on all other words
frame_count  out  C_CNT_WIDTH  frames completed, saturating
crc_err_count  out  C_CNT_WIDTH  frames with crc_err, saturating
len_err_count  out  C_CNT_WIDTH  frames with len_err, saturating

Behaviour:
- Frame format: a header word, then LEN payload words, then 1 checksum byte. Header bytes in wire order: byte0 = LEN (0..255 words), byte1 = src, byte2 = dest, byte3 = command. Checksum = XOR of every preceding byte in the frame.
- Reset (aresetn low): all outputs 0, counters 0, state IDLE, byte index 0, XOR accumulator 0. Reset may arrive mid-frame; the partial frame is discarded. clear does the same except the counters hold their values.
- FSM states:
  - IDLE: the first accepted byte goes to HDR.
  - HDR: when 4 header bytes are collected, latch LEN. The header word goes to the pending register. Go to PAYLOAD if LEN > 0, else CRC.
  - PAYLOAD: count words up to LEN, then go to CRC.
  - CRC: compare the byte with the accumulator. Flag crc_err on mismatch. If the CRC byte lacks tlast, set len_err and go to DRAIN; else go to IDLE.
  - DRAIN: discard bytes until a tlast byte is accepted, then go to IDLE.
- Hold-back rule: the frame's final word (header if LEN = 0, else the last payload word) is held in the pending register until the CRC byte is accepted. It is then emitted with tlast = 1 and tuser set. All other words are emitted with tlast = 0.
- Early tlast (tlast on any byte in HDR or PAYLOAD):
  - Zero-pad the partial word (unreceived upper bytes = 0).
  - Emit it with tlast = 1 and tuser[1] = 1, then go to IDLE.
  - If the partial word holds 0 bytes, re-emit the pending word with tlast and len_err instead.
- Latency:
  - A non-final word appears on m_axis the cycle after its 4th byte is accepted.
  - The final word appears the cycle after the CRC byte is accepted.
- Buffering: one output register plus one pending word register. s_axis_tready is low only when a newly completed word would need the pending slot while that slot cannot move into a full, stalled output register. Throughput is 1 byte per cycle with no bubbles while m_axis_tready is held high.
- m_axis handshake:
  - tdata, tlast and tuser are stable while tvalid is high and tready is low.
  - tvalid never drops without a handshake, except on reset or clear.
- Counters:
  - Counters update in the cycle the tlast word handshakes. frame_count increments every frame; each error counter increments when its flag is set.
  - Counters saturate at all-ones.
  - A frame with both flags increments both error counters.
- DRAIN bytes produce no output and no counter activity.

Decomposition:
- Package maple_pkg:
  - State enum {IDLE, HDR, PAYLOAD, CRC, DRAIN}.
  - Header byte index constants (LEN_IDX = 0, SRC_IDX = 1, DEST_IDX = 2, CMD_IDX = 3).
  - tuser bit constants (TUSER_CRC_ERR = 0, TUSER_LEN_ERR = 1).
- Sub-module maple_sat_counter (parameterised width, inc, clear-on-reset) is instantiated three times.
- Packing and the FSM stay in the top module.

Test Plan:
1. Good frame, bytes 01 20 00 01 AA BB CC DD 20 (tlast on the 20 checksum byte), tready = 1. Expect word 0x01002001 (tlast = 0), then 0xDDCCBBAA (tlast = 1, tuser = 0). frame_count = 1.
2. LEN = 0 frame, bytes 00 20 00 01 21 (tlast on 21). Expect a single word 0x01002000 with tlast = 1, tuser = 0.
3. Frame 1 with checksum byte 0x21 instead of 0x20. Expect 0xDDCCBBAA with tuser = 01. crc_err_count = 1.
4. Frame 1 truncated, tlast on byte BB. Expect 0x01002001, then 0x0000BBAA with tlast = 1, tuser = 10. len_err_count = 1.
5. Frame 1 with no tlast on the checksum byte, followed by 3 junk bytes (tlast on the third). Expect the final word tagged tuser = 10. Junk produces no output. The next good frame is decoded correctly.
6. Random m_axis_tready backpressure (~50%) over 100 random-LEN frames. Check output words against a reference model, no lost or duplicated data, and tdata stable while stalled. Assert aresetn mid-payload once: outputs go to 0 and the next frame is decoded cleanly.
